// File: rtl/pipelined_cpu_core.sv
// rtl/pipelined_cpu_core.sv - three-stage decode/execute/writeback core with execute forwarding
module pipelined_cpu_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 128,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   instr_valid_in,
    input  logic [31:0]            instr_in,
    output logic                   instr_ready_out,
    output logic                   result_valid_out,
    output logic [DATA_WIDTH-1:0]  result_out,
    output logic [6:0]             result_rd_out,
    output logic [COUNT_WIDTH-1:0] retired_count_out
);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [7:0] NREG = 8'(NUM_REGS);

    // Full 7-bit address space; entries at or above NUM_REGS are never written and read as 0
    logic [DATA_WIDTH-1:0] regs [128];

    logic                  d_valid;
    logic [6:0]            d_rd, d_rs1, d_rs2;
    logic [7:0]            d_imm;
    logic                  d_imm_sel;
    logic [2:0]            d_op;

    logic                  ex_valid;
    logic [6:0]            ex_rd;
    logic [DATA_WIDTH-1:0] ex_result;

    logic [DATA_WIDTH-1:0] op_a, reg_b, op_b, alu;
    logic [SHW-1:0]        shamt;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in[9:4];

    assign instr_ready_out = reset_in;

    always_comb begin
        op_a = '0;
        reg_b = '0;
        if (d_rs1 != 7'd0 && {1'b0, d_rs1} < NREG)
            op_a = regs[d_rs1];
        if (d_rs2 != 7'd0 && {1'b0, d_rs2} < NREG)
            reg_b = regs[d_rs2];
        // Execute-stage result overrides the register file for back-to-back dependencies
        if (ex_valid && ex_rd != 7'd0 && ex_rd == d_rs1)
            op_a = ex_result;
        if (ex_valid && ex_rd != 7'd0 && ex_rd == d_rs2)
            reg_b = ex_result;
        op_b  = d_imm_sel ? DATA_WIDTH'(d_imm) : reg_b;
        shamt = op_b[SHW-1:0];
        case (d_op)
            3'd0:    alu = op_a + op_b;
            3'd1:    alu = op_a - op_b;
            3'd2:    alu = op_a & op_b;
            3'd3:    alu = op_a | op_b;
            3'd4:    alu = op_a ^ op_b;
            3'd5:    alu = op_a << shamt;
            3'd6:    alu = op_a >> shamt;
            default: alu = op_b;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            d_valid           <= 1'b0;
            d_rd              <= '0;
            d_rs1             <= '0;
            d_rs2             <= '0;
            d_imm             <= '0;
            d_imm_sel         <= 1'b0;
            d_op              <= '0;
            ex_valid          <= 1'b0;
            ex_rd             <= '0;
            ex_result         <= '0;
            result_valid_out  <= 1'b0;
            result_out        <= '0;
            result_rd_out     <= '0;
            retired_count_out <= '0;
            for (int i = 0; i < 128; i++)
                regs[i] <= '0;
        end else begin
            d_valid <= instr_valid_in;
            if (instr_valid_in) begin
                d_rd      <= instr_in[31:25];
                d_rs1     <= instr_in[24:18];
                d_rs2     <= instr_in[17:11];
                d_imm     <= instr_in[17:10];
                d_imm_sel <= instr_in[3];
                d_op      <= instr_in[2:0];
            end
            ex_valid         <= d_valid;
            ex_rd            <= d_rd;
            ex_result        <= alu;
            result_valid_out <= ex_valid;
            if (ex_valid) begin
                result_out        <= ex_result;
                result_rd_out     <= ex_rd;
                retired_count_out <= retired_count_out + COUNT_WIDTH'(1);
                if (ex_rd != 7'd0 && {1'b0, ex_rd} < NREG)
                    regs[ex_rd] <= ex_result;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cpu_core.sv
// tb/tb_pipelined_cpu_core.sv - randomized and directed bench for pipelined_cpu_core
module tb_pipelined_cpu_core;
    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic        instr_valid_in = 1'b0;
    logic [31:0] instr_in = '0;
    logic        instr_ready_out;
    logic        result_valid_out;
    logic [7:0]  result_out;
    logic [6:0]  result_rd_out;
    logic [15:0] retired_count_out;

    pipelined_cpu_core #(.DATA_WIDTH(8), .NUM_REGS(128), .COUNT_WIDTH(16)) dut (
        .clock_in(clk),
        .reset_in(reset_in),
        .instr_valid_in(instr_valid_in),
        .instr_in(instr_in),
        .instr_ready_out(instr_ready_out),
        .result_valid_out(result_valid_out),
        .result_out(result_out),
        .result_rd_out(result_rd_out),
        .retired_count_out(retired_count_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Architectural state and per-edge retire schedule
    int mregs [128];
    bit sched_v [8192];
    int sched_rd [8192];
    int sched_res [8192];
    bit rst_at [8192];

    int obs_edge [$];
    int obs_rd [$];
    int obs_res [$];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    function automatic int model_exec(input logic [31:0] w);
        int a, b, sh, r;
        a = mregs[w[24:18]];
        b = w[3] ? int'(w[17:10]) : mregs[w[17:11]];
        sh = b % 8;
        case (w[2:0])
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: r = b;
        endcase
        return r & 255;
    endfunction

    // Drives one edge worth of inputs and updates the model for that edge
    task automatic drive(input bit v, input logic [31:0] w, input bit rstn);
        int e, r;
        e = edge_n + 1;
        reset_in = rstn;
        instr_valid_in = v;
        instr_in = w;
        if (!rstn) begin
            rst_at[e] = 1'b1;
            sched_v[e] = 1'b0;
            sched_v[e + 1] = 1'b0;
            for (int i = 0; i < 128; i++) mregs[i] = 0;
        end else if (v) begin
            r = model_exec(w);
            if (w[31:25] != 7'd0) mregs[w[31:25]] = r;
            sched_v[e + 2] = 1'b1;
            sched_rd[e + 2] = int'(w[31:25]);
            sched_res[e + 2] = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b1);
    endtask

    function automatic logic [31:0] ri(input int op, input int rd, input int rs1, input int imm);
        logic [6:0] d, s;
        logic [7:0] im;
        logic [2:0] o;
        d = 7'(rd); s = 7'(rs1); im = 8'(imm); o = 3'(op);
        return {d, s, im, 6'b0, 1'b1, o};
    endfunction

    function automatic logic [31:0] rr(input int op, input int rd, input int rs1, input int rs2);
        logic [6:0] d, s1, s2;
        logic [2:0] o;
        d = 7'(rd); s1 = 7'(rs1); s2 = 7'(rs2); o = 3'(op);
        return {d, s1, s2, 7'b0, 1'b0, o};
    endfunction

    task automatic chk_obs(input string nm, input int idx, input int ed, input int rd, input int res);
        if (idx >= obs_rd.size()) begin
            chk({nm, "_present"}, obs_rd.size(), idx + 1);
        end else begin
            chk({nm, "_edge"}, obs_edge[idx], ed);
            chk({nm, "_rd"}, obs_rd[idx], rd);
            chk({nm, "_res"}, obs_res[idx], res);
        end
    endtask

    // Per-cycle comparison against the schedule
    initial begin
        int m, exp_count, last_res, last_rd;
        bit exp_v;
        exp_count = 0; last_res = 0; last_rd = 0;
        forever begin
            @(negedge clk);
            m = edge_n;
            if (m == 0) continue;
            if (rst_at[m]) begin
                exp_count = 0; last_res = 0; last_rd = 0; exp_v = 0;
            end else if (sched_v[m]) begin
                exp_count = (exp_count + 1) % 65536;
                last_res = sched_res[m]; last_rd = sched_rd[m]; exp_v = 1;
            end else begin
                exp_v = 0;
            end
            chk("result_valid", int'(result_valid_out), int'(exp_v));
            chk("result_out", int'(result_out), last_res);
            chk("result_rd", int'(result_rd_out), last_rd);
            chk("retired_count", int'(retired_count_out), exp_count);
            chk("instr_ready", int'(instr_ready_out), int'(reset_in));
            if (result_valid_out) begin
                obs_edge.push_back(m);
                obs_rd.push_back(int'(result_rd_out));
                obs_res.push_back(int'(result_res_sample()));
            end
        end
    end

    function automatic int result_res_sample();
        return int'(result_out);
    endfunction

    initial begin
        int base, e0;
        logic [31:0] w;
        for (int i = 0; i < 128; i++) mregs[i] = 0;

        for (int i = 0; i < 3; i++) drive(1'b1, ri(7, 1, 0, 8'h2A), 1'b0);
        chk("reset_result_out", int'(result_out), 0);
        chk("reset_count", int'(retired_count_out), 0);
        reset_in = 1'b1;
        #1;
        chk("ready_after_reset", int'(instr_ready_out), 1);

        base = obs_rd.size(); e0 = edge_n + 1;
        drive(1'b1, ri(7, 1, 0, 8'h2A), 1'b1);
        idle(3);
        chk_obs("pass_imm", base, e0 + 2, 1, 8'h2A);
        chk("pass_imm_count", int'(retired_count_out), 1);

        base = obs_rd.size(); e0 = edge_n + 1;
        drive(1'b1, ri(7, 1, 0, 5), 1'b1);
        drive(1'b1, ri(7, 2, 0, 7), 1'b1);
        drive(1'b1, rr(0, 3, 1, 2), 1'b1);
        drive(1'b1, rr(1, 4, 3, 1), 1'b1);
        idle(3);
        chk_obs("fwd_r1", base, e0 + 2, 1, 5);
        chk_obs("fwd_r2", base + 1, e0 + 3, 2, 7);
        chk_obs("fwd_add", base + 2, e0 + 4, 3, 12);
        chk_obs("fwd_sub", base + 3, e0 + 5, 4, 7);

        base = obs_rd.size(); e0 = edge_n + 1;
        drive(1'b1, ri(7, 1, 0, 8'hFF), 1'b1);
        drive(1'b1, ri(0, 1, 1, 1), 1'b1);
        drive(1'b1, ri(7, 5, 0, 8'h81), 1'b1);
        drive(1'b1, ri(5, 5, 5, 9), 1'b1);
        drive(1'b1, ri(7, 7, 0, 8'h80), 1'b1);
        drive(1'b1, ri(6, 7, 7, 7), 1'b1);
        idle(3);
        chk_obs("wrap_addi", base + 1, e0 + 3, 1, 8'h00);
        chk_obs("shl_mask", base + 3, e0 + 5, 5, 8'h02);
        chk_obs("shr", base + 5, e0 + 7, 7, 8'h01);

        base = obs_rd.size(); e0 = edge_n + 1;
        drive(1'b1, ri(7, 0, 0, 8'h55), 1'b1);
        drive(1'b1, rr(0, 6, 0, 0), 1'b1);
        idle(3);
        chk_obs("r0_pass", base, e0 + 2, 0, 8'h55);
        chk_obs("r0_add", base + 1, e0 + 3, 6, 8'h00);
        chk("r0_count", int'(retired_count_out), 13);
        base = obs_rd.size();
        idle(2);
        chk("gap_count", int'(retired_count_out), 13);
        chk("gap_no_pulse", obs_rd.size(), base);

        base = obs_rd.size();
        drive(1'b1, ri(7, 9, 0, 8'h11), 1'b1);
        drive(1'b1, ri(7, 10, 0, 8'h22), 1'b1);
        drive(1'b1, ri(7, 11, 0, 8'h33), 1'b0);
        e0 = edge_n + 1;
        drive(1'b1, rr(0, 8, 2, 9), 1'b1);
        idle(3);
        chk("midrst_one_retire", obs_rd.size(), base + 1);
        chk_obs("midrst_regs_clear", base, e0 + 2, 8, 0);
        chk("midrst_count", int'(retired_count_out), 1);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                drive($urandom_range(0, 1) == 1, $urandom, 1'b0);
            end else begin
                w = $urandom;
                w[31:25] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
                w[24:18] = 7'($urandom_range(0, 7));
                if (!w[3]) w[17:11] = 7'($urandom_range(0, 7));
                drive($urandom_range(0, 4) != 0, w, 1'b1);
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_cpu_core.md
# pipelined_cpu_core

Parametrised three-stage (decode/read, execute, writeback) successor to the single-cycle datapath. It takes 32-bit instructions over a valid/ready handshake and reads operands from an internal register file. Operand B is either a register or an 8-bit immediate, and results are forwarded from execute so back-to-back dependent instructions never stall. Writeback results and a retired-instruction count go to the top level, where they replace the old `cpu_output`.

## Interface
- `DATA_WIDTH`, 8: register and ALU width, 8..32.
- `NUM_REGS`, 128: register count, at most 128; addresses use 7 bits, and indices ≥ NUM_REGS read 0 and ignore writes.
- `COUNT_WIDTH`, 16: width of the retired counter.
- `clock_in` in 1: sole clock; everything updates on the rising edge.
- `reset_in` in 1: synchronous, active-low reset.
- `instr_valid_in` in 1: `instr_in` is valid.
- `instr_in` in 32: bits [31:25] rd, [24:18] rs1, [17:11] rs2, [17:10] imm8, [3] imm_sel, [2:0] opcode; [10:4] unused when imm_sel=0.
- `instr_ready_out` out 1: the core accepts an instruction this cycle.
- `result_valid_out` out 1: one-cycle pulse per retired instruction.
- `result_out` out DATA_WIDTH: writeback value.
- `result_rd_out` out 7: writeback destination.
- `retired_count_out` out COUNT_WIDTH: count of retired instructions.

## Operation
- **Accept:** an instruction is accepted when `instr_valid_in` and `instr_ready_out` are both high at a rising edge. `instr_ready_out` is 0 while `reset_in`=0 and 1 otherwise; the core never stalls.
- **Opcodes** (A = rs1 data; B = rs2 data, or imm8 when imm_sel=1):
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: A << B[log2(DATA_WIDTH)−1:0]
  - 6 SHR: logical, same shift rule as SHL
  - 7 PASS: B
- **Arithmetic:** results are truncated to DATA_WIDTH and wrap modulo 2^DATA_WIDTH. There are no flags.
- **Immediate:** imm8 is zero-extended to DATA_WIDTH. If DATA_WIDTH<8 it is truncated to the low bits.
- **Register 0:** always reads 0, and writes to it are discarded. It still retires: the valid pulse fires and the counter increments.
- **Register file:** asynchronous read, synchronous write at writeback. All entries clear to 0 on reset.
- **Forwarding:** if the execute-stage instruction is valid, has rd≠0, and its rd equals rs1 (or rs2 with imm_sel=0) of the decode-stage instruction, the execute-stage result replaces the register-file data.
  - Forwarding takes priority over the register file.
  - No writeback forward is needed, because the write lands at the same edge the next reader's operands are sampled.
- **Pipeline valids:** each stage has a valid bit. A bubble (no accept) propagates as valid=0 and produces no write, no pulse and no count.
- **Counter:** `retired_count_out` increments on each retire and wraps at 2^COUNT_WIDTH.

## Timing
- **Reset values:** while `reset_in`=0 at an edge, all stage valids clear, `result_valid_out`=0, `result_out`=0, `result_rd_out`=0, `retired_count_out`=0, and all registers clear to 0.
- **Reset mid-operation:** in-flight instructions are dropped with no writes. An instruction presented during reset is not accepted.
- **Latency:** for an instruction accepted at edge k:
  - it sits in decode during cycle k..k+1, and the ALU result registers at edge k+1;
  - the register-file write, `result_*` and the counter update at edge k+2.
  - The result is visible on outputs in the cycle after edge k+2.
- **Throughput:** one instruction per cycle sustained.
- **Outputs:** `result_out` and `result_rd_out` hold their last value when `result_valid_out`=0.

## Test plan
- **Reset:** drive 3 cycles of `reset_in`=0 with `instr_valid_in`=1 → no accept, all outputs 0. After release, `instr_ready_out`=1.
- **Immediate PASS:** PASS imm r1←0x2A accepted at edge k → `result_valid_out`=1, `result_rd_out`=1 and `result_out`=0x2A after edge k+2; `retired_count_out`=1.
- **Back-to-back forwarding:** r1←5, r2←7, then ADD r3=r1+r2 and SUB r4=r3−r1 on consecutive cycles → results 5, 7, 12, 7 on consecutive cycles with no bubbles.
- **Wrap and shift** (DATA_WIDTH=8): r1←0xFF then ADDI r1+1 → 0x00. SHL r5=0x81<<9 → 0x02, since the shift amount is masked to 1. SHR 0x80 by 7 → 0x01.
- **r0 and bubbles:** PASS r0←0x55, then ADD r6=r0+r0 → r6 reads 0x00 and both instructions retire. A valid gap of 2 cycles → no pulses during the gap and the counter unchanged.
- **Reset mid-stream:** accept 2 instructions, then assert reset the next edge → neither retires, and the registers and counter read 0 afterwards.
